// File: rtl/score_pkg.sv
// Shared constants for the score display path: FSM state encoding and BCD/segment values.
package score_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int          BCD_W     = 4;
    localparam logic [3:0]  BCD_NINE  = 4'd9;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    // Double-dabble correction threshold for one BCD nibble.
    function automatic logic bcd_needs_adj(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5);
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Conversion handshake and display outputs between the scoring logic and the HEX digit decoders.
interface score_display_ctrl_if
    import score_pkg::*;
#(
    parameter int BIN_W      = 10,
    parameter int NUM_DIGITS = 3
);
    logic                        start;
    logic [BIN_W-1:0]            score_bin;
    logic                        busy;
    logic                        done;
    logic                        overflow;
    logic [BCD_W*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]       digit_blank;

    modport master (
        output start, score_bin,
        input  busy, done, overflow, digits, digit_blank
    );

    modport slave (
        input  start, score_bin,
        output busy, done, overflow, digits, digit_blank
    );
endinterface

// File: rtl/score_display_ctrl_bcd_add3.sv
// Combinational double-dabble cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    // Nibble correction ahead of the left shift.
    always_comb begin
        if (bcd_needs_adj(d)) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to BCD display digits via a sequential double-dabble with start/busy/done handshake.
// Optional build macro: BLANK_LEADING_ZERO_EN enables leading-zero blank requests.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int BIN_W      = 10,
    parameter int NUM_DIGITS = 3
)(
    input  logic                 clk,
    input  logic                 reset,
    score_display_ctrl_if.slave  bus
);

    localparam int BCD_TOT = BCD_W * NUM_DIGITS;
    // Guard bits collect the quotient above 10^NUM_DIGITS in plain binary; BIN_W bits can never overflow.
    localparam int GUARD_W = BIN_W;
    localparam int ACC_W   = GUARD_W + BCD_TOT + BIN_W;
    localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [ACC_W-1:0]      acc_r;
    logic [BCD_TOT-1:0]    adj_bcd_s;
    logic [ACC_W-1:0]      adj_s;
    logic [BCD_TOT-1:0]    bcd_s;
    logic [GUARD_W-1:0]    guard_s;
    logic                  ovf_s;
    logic [BCD_TOT-1:0]    res_digits_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic                  accept_s;

    logic                  busy_r;
    logic                  done_r;
    logic                  overflow_r;
    logic [BCD_TOT-1:0]    digits_r;
    logic [NUM_DIGITS-1:0] blank_r;

    assign bcd_s    = acc_r[BIN_W +: BCD_TOT];
    assign guard_s  = acc_r[ACC_W-1 -: GUARD_W];
    assign ovf_s    = |guard_s;
    assign accept_s = (state_r == IDLE) && bus.start;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .d (acc_r[BIN_W + g*BCD_W +: BCD_W]),
                .q (adj_bcd_s[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    assign adj_s = {guard_s, adj_bcd_s, acc_r[BIN_W-1:0]};

    // Result digits: saturate to all nines when anything spilled into the guard bits.
    always_comb begin
        res_digits_s = {BCD_TOT{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_s) begin
                res_digits_s[i*BCD_W +: BCD_W] = BCD_NINE;
            end else begin
                res_digits_s[i*BCD_W +: BCD_W] = bcd_s[i*BCD_W +: BCD_W];
            end
        end
    end

    // Blank requests for leading zeros, scanning from the most significant digit down.
    always_comb begin
        blank_s = {NUM_DIGITS{1'b0}};
`ifdef BLANK_LEADING_ZERO_EN
        begin : blk_scan
            logic seen_nz;
            seen_nz = 1'b0;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                if (res_digits_s[i*BCD_W +: BCD_W] != 4'd0) begin
                    seen_nz = 1'b1;
                end else begin
                    seen_nz = seen_nz;
                end
                blank_s[i] = ~seen_nz;
            end
        end
`else
        blank_s = {NUM_DIGITS{1'b0}};
`endif
    end

    // Next-state decode for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer, shift datapath and held output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            digits_r   <= {BCD_TOT{1'b0}};
            blank_r    <= {NUM_DIGITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_r == DONE);
            // Busy stays high through the done cycle so the handshake never shows a gap.
            busy_r  <= (state_r == DONE) || (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r <= {{(GUARD_W + BCD_TOT){1'b0}}, bus.score_bin};
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    acc_r <= adj_s << 1'b1;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                DONE: begin
                    digits_r   <= res_digits_s;
                    overflow_r <= ovf_s;
                    blank_r    <= blank_s;
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.overflow    = overflow_r;
    assign bus.digits      = digits_r;
    assign bus.digit_blank = blank_r;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed handshake cases plus random scores vs a decimal model.
module tb_score_display_ctrl;
    import score_pkg::*;

    localparam int BIN_W = 10;
    localparam int ND    = 3;
    localparam int LAT   = BIN_W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_display_ctrl_if #(.BIN_W(BIN_W), .NUM_DIGITS(ND)) bus ();

    score_display_ctrl #(.BIN_W(BIN_W), .NUM_DIGITS(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [11:0] prev_dig = 12'h000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic logic [11:0] m_dig(input int v);
        int d;
        d = clamp(v);
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    function automatic logic [2:0] m_blank(input int v);
        int d;
        d = clamp(v);
`ifdef BLANK_LEADING_ZERO_EN
        return {d < 100, d < 10, 1'b0};
`else
        return (d < 0) ? 3'b111 : 3'b000;
`endif
    endfunction

    task automatic conv(input int v);
        int n;
        bus.score_bin = v[9:0];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk($sformatf("v%0d_busy_hi", v), 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 5) chk($sformatf("v%0d_hold", v), 32'(bus.digits), 32'(prev_dig));
        end
        chk($sformatf("v%0d_latency", v), 32'(n), 32'(LAT));
        chk($sformatf("v%0d_digits", v), 32'(bus.digits), 32'(m_dig(v)));
        chk($sformatf("v%0d_ovf", v), 32'(bus.overflow), 32'(v > 999));
        chk($sformatf("v%0d_blank", v), 32'(bus.digit_blank), 32'(m_blank(v)));
        chk($sformatf("v%0d_busy_done", v), 32'(bus.busy), 32'd1);
        tick();
        chk($sformatf("v%0d_done_pulse", v), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d_busy_lo", v), 32'(bus.busy), 32'd0);
        prev_dig = m_dig(v);
    endtask

    initial begin
        int n;
        int dones;
        int v1;
        int v2;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.score_bin = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_digits", 32'(bus.digits), 32'h000);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_blank", 32'(bus.digit_blank), 32'd0);
        reset = 1'b0;
        tick();

        conv(347);
        conv(1000);
        conv(5);
        conv(7);
        conv(0);
        conv(40);
        conv(999);
        conv(1023);

        // start pulses while busy are ignored
        bus.score_bin = 10'd123;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.score_bin = 10'd456;
        tick(); tick(); tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        bus.start = 1'b1;
        tick();
        chk("busy_ign_done", 32'(bus.done), 32'd1);
        chk("busy_ign_digits", 32'(bus.digits), 32'h123);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        chk("busy_ign_extra_done", 32'(dones), 32'd0);
        prev_dig = 12'h123;

        // reset in the middle of SHIFT
        bus.score_bin = 10'd999;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_digits", 32'(bus.digits), 32'h000);
        chk("midrst_ovf", 32'(bus.overflow), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        prev_dig = 12'h000;

        // start held high: back-to-back conversions
        v1 = int'($urandom_range(0, 1023));
        v2 = int'($urandom_range(0, 1023));
        bus.score_bin = v1[9:0];
        bus.start = 1'b1;
        tick();
        bus.score_bin = v2[9:0];
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_first_lat", 32'(n), 32'(LAT));
        chk("b2b_first_digits", 32'(bus.digits), 32'(m_dig(v1)));
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 40);
        chk("b2b_period", 32'(n), 32'(BIN_W + 2));
        chk("b2b_second_digits", 32'(bus.digits), 32'(m_dig(v2)));
        chk("b2b_second_ovf", 32'(bus.overflow), 32'(v2 > 999));
        bus.start = 1'b0;
        tick();
        tick();
        chk("b2b_busy_lo", 32'(bus.busy), 32'd0);
        prev_dig = m_dig(v2);

        for (int k = 0; k < 15; k++) begin
            conv(int'($urandom_range(0, 1023)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
